// File: rtl/video_pkg.sv
// Shared types and defaults for the video capture/pack stage.
package video_pkg;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    FRAME,
    LINE,
    DROP
  } cap_state_t;

  typedef logic [7:0] pixel_t;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int PPW_DEF    = 4;

endpackage

// File: rtl/video_in_pack_if.sv
// Camera stream in, packed FIFO words out.
interface video_in_pack_if;
  import video_pkg::*;

  logic        clk_in;
  pixel_t      pixel_in;
  logic        frame_valid;
  logic        line_valid;
  logic        fifo_full;
  logic [31:0] data_out;
  logic        w_en;
  logic        sof;

  modport master (
    input  clk_in, pixel_in, frame_valid,
    input  line_valid, fifo_full,
    output data_out, w_en, sof
  );

  modport slave (
    output clk_in, pixel_in, frame_valid,
    output line_valid, fifo_full,
    input  data_out, w_en, sof
  );

endinterface

// File: rtl/video_in_pack_edge.sv
// Falling-edge detector for a slow clock sampled as data.
module clk_edge_det (
  input  logic clk,
  input  logic RST,
  input  logic sig_in,
  output logic fall_pulse
);

  logic old;

  always_ff @(posedge clk) begin
    if (RST) old <= 1'b0;
    else     old <= sig_in;
  end

  assign fall_pulse = old & ~sig_in;

endmodule

// File: rtl/video_in_pack.sv
// Samples the pixel stream on clk_in falling edges, checks geometry,
// packs pixels into 32-bit words for the frame FIFO.
module video_in_pack
  import video_pkg::*;
#(
  parameter int P_WIDTH      = DEF_WIDTH,
  parameter int P_HEIGHT     = DEF_HEIGHT,
  parameter int PIX_PER_WORD = PPW_DEF
) (
  input  logic        clk,
  input  logic        RST,
  video_in_pack_if.master bus,
  input  logic        clr_err,
  output logic        overflow,
  output logic        size_err,
  output logic [15:0] frame_cnt
);

  localparam int PW = $clog2(P_WIDTH + 2);
  localparam int LN = $clog2(P_HEIGHT + 2);
  localparam int LW = $clog2(PIX_PER_WORD);

  localparam logic [PW-1:0] WIDTH_C   = PW'(P_WIDTH);
  localparam logic [PW-1:0] PIX_MAX   = PW'(P_WIDTH + 1);
  localparam logic [LN-1:0] HEIGHT_C  = LN'(P_HEIGHT);
  localparam logic [LN-1:0] LINE_MAX  = LN'(P_HEIGHT + 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(PIX_PER_WORD - 1);

  typedef logic [PIX_PER_WORD-1:0][7:0] lanes_t;

  cap_state_t  state, state_n;
  logic [PW-1:0] pix_cnt, pix_n;
  logic [LN-1:0] line_cnt, line_n, lines;
  lanes_t      lanes, lanes_n;
  logic        first_word, first_n;
  logic        frame_bad, bad_n;
  logic [31:0] data_n;
  logic        wen_n, sof_n;
  logic        ovf_set, size_set;
  logic [15:0] fcnt_n;
  logic        line_end, frame_end;
  logic        ev, fv, lv;
  pixel_t      pix;
  logic [LW-1:0] lane;

  clk_edge_det u_edge (
    .clk       (clk),
    .RST       (RST),
    .sig_in    (bus.clk_in),
    .fall_pulse(ev)
  );

  assign fv   = bus.frame_valid;
  assign lv   = bus.line_valid & fv;
  assign pix  = bus.pixel_in;
  assign lane = pix_cnt[LW-1:0];

  always_comb begin
    state_n   = state;
    pix_n     = pix_cnt;
    line_n    = line_cnt;
    lanes_n   = lanes;
    first_n   = first_word;
    bad_n     = frame_bad;
    data_n    = bus.data_out;
    wen_n     = 1'b0;
    sof_n     = 1'b0;
    ovf_set   = 1'b0;
    size_set  = 1'b0;
    fcnt_n    = frame_cnt;
    line_end  = 1'b0;
    frame_end = 1'b0;
    lines     = line_cnt;

    if (ev) begin
      case (state)
        SYNC: if (!fv) state_n = IDLE;
        IDLE: begin
          if (fv) begin
            state_n = FRAME;
            line_n  = '0;
            first_n = 1'b1;
            bad_n   = 1'b0;
          end
        end
        FRAME: begin
          if (!fv) begin
            state_n   = IDLE;
            frame_end = 1'b1;
          end else if (lv) begin
            state_n    = LINE;
            lanes_n[0] = pix;
            pix_n      = PW'(1);
          end
        end
        LINE: begin
          if (lv) begin
            pix_n = (pix_cnt == PIX_MAX) ? pix_cnt : pix_cnt + PW'(1);
            // pixels past the line width are counted but never packed
            if (pix_cnt < WIDTH_C) begin
              lanes_n[lane] = pix;
              if (lane == LANE_LAST) begin
                if (bus.fifo_full) begin
                  ovf_set = 1'b1;
                  state_n = DROP;
                end else begin
                  wen_n   = 1'b1;
                  data_n  = lanes_n;
                  sof_n   = first_word;
                  first_n = 1'b0;
                end
              end
            end
          end else begin
            line_end  = 1'b1;
            frame_end = !fv;
            state_n   = fv ? FRAME : IDLE;
          end
        end
        DROP: if (!fv) state_n = IDLE;
        default: state_n = SYNC;
      endcase
    end

    if (line_end) begin
      lines  = (line_cnt == LINE_MAX) ? line_cnt : line_cnt + LN'(1);
      line_n = lines;
      if (pix_cnt != WIDTH_C) begin
        size_set = 1'b1;
        bad_n    = 1'b1;
      end
    end

    if (frame_end) begin
      if (lines != HEIGHT_C) size_set = 1'b1;
      else if (!bad_n)       fcnt_n   = frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state        <= SYNC;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      lanes        <= '0;
      first_word   <= 1'b0;
      frame_bad    <= 1'b0;
      bus.data_out <= '0;
      bus.w_en     <= 1'b0;
      bus.sof      <= 1'b0;
      overflow     <= 1'b0;
      size_err     <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_n;
      pix_cnt      <= pix_n;
      line_cnt     <= line_n;
      lanes        <= lanes_n;
      first_word   <= first_n;
      frame_bad    <= bad_n;
      bus.data_out <= data_n;
      bus.w_en     <= wen_n;
      bus.sof      <= sof_n;
      overflow     <= (overflow & ~clr_err) | ovf_set;
      size_err     <= (size_err & ~clr_err) | size_set;
      frame_cnt    <= fcnt_n;
    end
  end

endmodule

// File: tb/tb_video_in_pack.sv
// Frame-level bench: table of frames plus hand sequences, scoreboard on w_en.
module tb_video_in_pack;

  localparam int W = 8;
  localparam int H = 4;

  typedef struct {
    string name;
    int    lines;
    int    bad_line;
    int    bad_w;
    int    full_word;
    int    base;
    int    exp_size;
    int    exp_ovf;
    int    exp_inc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_err;
  logic        overflow;
  logic        size_err;
  logic [15:0] frame_cnt;

  video_in_pack_if bus ();

  video_in_pack #(
    .P_WIDTH (W),
    .P_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .RST      (rst),
    .bus      (bus),
    .clr_err  (clr_err),
    .overflow (overflow),
    .size_err (size_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [32:0] q[$];
  logic        sb_first;
  logic        sb_drop;
  int          sb_wn;
  int          fc;
  vec_t        vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.w_en === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_w_en: got data %h expected no write",
                 bus.data_out);
      end else begin
        logic [32:0] e;
        e = q.pop_front();
        chk("word_data", bus.data_out, e[31:0]);
        chk("word_sof", {31'd0, bus.sof}, {31'd0, e[32]});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic pclk(input logic fv, input logic lv,
                      input logic [7:0] px, input logic clr);
    bus.frame_valid = fv;
    bus.line_valid  = lv;
    bus.pixel_in    = px;
    bus.clk_in      = 1'b1;
    repeat (4) @(negedge clk);
    bus.clk_in = 1'b0;
    clr_err    = clr;
    @(negedge clk);
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_frame();
    sb_first = 1'b1;
    sb_drop  = 1'b0;
    sb_wn    = 0;
    pclk(0, 0, 8'd0, 0);
    pclk(0, 0, 8'd0, 0);
    pclk(1, 0, 8'd0, 0);
  endtask

  task automatic end_frame();
    pclk(0, 0, 8'd0, 0);
    pclk(0, 0, 8'd0, 0);
  endtask

  task automatic send_line(input int base, input int w,
                           input int full_word, input logic clr_end);
    logic [31:0] wd;
    logic [7:0]  px;
    wd = '0;
    for (int p = 0; p < w; p++) begin
      px = 8'(base + p);
      wd[8*(p%4) +: 8] = px;
      if (p % 4 == 3 && p < W) begin
        sb_wn++;
        if (full_word == sb_wn) begin
          bus.fifo_full = 1'b1;
          sb_drop = 1'b1;
        end else if (!sb_drop) begin
          q.push_back({sb_first, wd});
          sb_first = 1'b0;
        end
      end
      pclk(1, 1, px, 0);
      bus.fifo_full = 1'b0;
    end
    pclk(1, 0, 8'd0, clr_end);
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v);
    start_frame();
    for (int l = 0; l < v.lines; l++)
      send_line(v.base + l * W, (l == v.bad_line) ? v.bad_w : W,
                v.full_word, 0);
    end_frame();
    if (v.exp_inc != 0) fc++;
    chk({v.name, "_size_err"}, {31'd0, size_err}, 32'(v.exp_size));
    chk({v.name, "_overflow"}, {31'd0, overflow}, 32'(v.exp_ovf));
    chk({v.name, "_frame_cnt"}, {16'd0, frame_cnt}, 32'(fc));
    chk({v.name, "_words_left"}, 32'(q.size()), 32'd0);
    clr_pulse();
    chk({v.name, "_clr"}, {30'd0, size_err, overflow}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"clean",      4, -1, 8, 0,   0, 0, 0, 1};
    vecs[1] = '{"short_line", 4,  1, 6, 0,  40, 1, 0, 0};
    vecs[2] = '{"ovf_w3",     4, -1, 8, 3,  80, 0, 1, 0};
    vecs[3] = '{"after_ovf",  4, -1, 8, 0, 120, 0, 0, 1};
    vecs[4] = '{"few_lines",  3, -1, 8, 0, 160, 1, 0, 0};
    vecs[5] = '{"many_lines", 5, -1, 8, 0, 200, 1, 0, 0};

    rst             = 1'b1;
    clr_err         = 1'b0;
    bus.clk_in      = 1'b0;
    bus.pixel_in    = '0;
    bus.frame_valid = 1'b0;
    bus.line_valid  = 1'b0;
    bus.fifo_full   = 1'b0;
    fc              = 0;
    repeat (4) @(negedge clk);
    chk("rst_w_en", {31'd0, bus.w_en}, 32'd0);
    chk("rst_sof", {31'd0, bus.sof}, 32'd0);
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_size_err", {31'd0, size_err}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // reset in the middle of line 1, released with frame_valid still high
    start_frame();
    send_line(0, W, 0, 0);
    pclk(1, 1, 8'd50, 0);
    pclk(1, 1, 8'd51, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    fc  = 0;
    for (int p = 2; p < W; p++) pclk(1, 1, 8'(50 + p), 0);
    pclk(1, 0, 8'd0, 0);
    for (int p = 0; p < W; p++) pclk(1, 1, 8'(60 + p), 0);
    pclk(1, 0, 8'd0, 0);
    end_frame();
    chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("midrst_size_err", {31'd0, size_err}, 32'd0);
    chk("midrst_words_left", 32'(q.size()), 32'd0);
    run_frame('{"post_rst", 4, -1, 8, 0, 7, 0, 0, 1});

    // clear coinciding with a fresh line-length error
    start_frame();
    send_line(100, 6, 0, 0);
    chk("coinc_pre", {31'd0, size_err}, 32'd1);
    send_line(110, 6, 0, 1);
    chk("coinc_err_wins", {31'd0, size_err}, 32'd1);
    end_frame();
    chk("coinc_frame_cnt", {16'd0, frame_cnt}, 32'(fc));
    chk("coinc_words_left", 32'(q.size()), 32'd0);
    clr_pulse();
    chk("coinc_clr", {31'd0, size_err}, 32'd0);

    // line_valid toggling outside a frame
    for (int k = 0; k < 6; k++) pclk(0, 1, 8'(k + 1), 0);
    chk("lvonly_size_err", {31'd0, size_err}, 32'd0);
    chk("lvonly_overflow", {31'd0, overflow}, 32'd0);
    chk("lvonly_frame_cnt", {16'd0, frame_cnt}, 32'(fc));
    run_frame('{"post_lvonly", 4, -1, 8, 0, 33, 0, 0, 1});

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
